// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny post-NMS window stage.
package canny_pkg;

  localparam int unsigned MAG_W = 16;

  // Line-scan FSM: accept pixels, one end-of-line bubble, last-row flush
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    EOL   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // 3x3 window: centre plus neighbours named n<row offset><col offset>
  typedef struct packed {
    logic [MAG_W-1:0] c;
    logic [MAG_W-1:0] n00;
    logic [MAG_W-1:0] n01;
    logic [MAG_W-1:0] n02;
    logic [MAG_W-1:0] n10;
    logic [MAG_W-1:0] n12;
    logic [MAG_W-1:0] n20;
    logic [MAG_W-1:0] n21;
    logic [MAG_W-1:0] n22;
  } win_t;

  // Counter width able to index 0..n-1 (at least one bit)
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/canny_line_buf.sv
// One-row delay line: write the new pixel and read the pixel one row older at the same address.
module canny_line_buf
  import canny_pkg::*;
#(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [MAG_W-1:0] wdata,
  output logic [MAG_W-1:0] rdata
);

  logic [MAG_W-1:0] mem [DEPTH];

  // Row storage; contents never need reset because stale data is masked downstream
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read-before-write: returns the previous row's pixel at this column
  assign rdata = mem[addr];

endmodule

// File: rtl/mag_window_3x3.sv
// 3x3 window generator over a raster magnitude stream, with border handling.
// Optional macro MAG_WINDOW_REPLICATE_EN: out-of-image neighbours replicate the
// nearest edge pixel instead of reading zero.
module mag_window_3x3
  import canny_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_sof,
  output logic             out_valid,
  output logic [MAG_W-1:0] c,
  output logic [MAG_W-1:0] n00,
  output logic [MAG_W-1:0] n01,
  output logic [MAG_W-1:0] n02,
  output logic [MAG_W-1:0] n10,
  output logic [MAG_W-1:0] n12,
  output logic [MAG_W-1:0] n20,
  output logic [MAG_W-1:0] n21,
  output logic [MAG_W-1:0] n22,
  output logic             out_sof,
  output logic             out_eof,
  output logic             frame_err
);

  localparam int unsigned   CW       = idx_w(IMG_W);
  localparam int unsigned   RW       = idx_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d, rd_addr;
  logic [RW-1:0]    row_q, row_d;
  logic             accept, resync, emit, shift_en, lb_we;
  logic [CW-1:0]    cx;
  logic [RW-1:0]    cy;
  logic [MAG_W-1:0] lb1_rd, lb2_rd;
  logic [MAG_W-1:0] new_col [3];
  logic [MAG_W-1:0] w_q     [3][2];
  logic [MAG_W-1:0] w_n     [3][3];
  logic [MAG_W-1:0] win_a   [3][3];
  logic             top_out, bot_out, left_out, right_out;
  win_t             win_d, win_q;

  assign in_ready = (state_q == RUN);
  assign accept   = in_valid & in_ready;
  // An sof anywhere but the expected first pixel restarts the frame
  assign resync   = accept & in_sof & ((col_q != '0) | (row_q != '0));

  // Next-state, counters, line-buffer control and emitted window centre
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    emit     = 1'b0;
    shift_en = 1'b0;
    lb_we    = 1'b0;
    rd_addr  = col_q;
    cx       = '0;
    cy       = '0;
    case (state_q)
      RUN: begin
        if (accept) begin
          shift_en = 1'b1;
          lb_we    = 1'b1;
          if (resync) begin
            rd_addr = '0;
            col_d   = CW'(1);
            row_d   = '0;
          end else begin
            emit = (col_q != '0) && (row_q != '0);
            cx   = col_q - 1'b1;
            cy   = row_q - 1'b1;
            if (col_q == COL_LAST) begin
              col_d   = '0;
              state_d = EOL;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      EOL: begin
        // Shifts in column 0 (masked here) so the flush starts with it preloaded
        shift_en = 1'b1;
        emit     = (row_q != '0);
        cx       = COL_LAST;
        cy       = row_q - 1'b1;
        if (row_q == ROW_LAST) begin
          state_d = FLUSH;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = RUN;
        end
      end
      FLUSH: begin
        // col counts flush cycles; read one column ahead of the emitted centre
        shift_en = 1'b1;
        emit     = 1'b1;
        cx       = col_q;
        cy       = ROW_LAST;
        rd_addr  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_d   = '0;
          row_d   = '0;
          state_d = RUN;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // FSM and position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  canny_line_buf #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb1 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (rd_addr),
    .wdata (in_mag),
    .rdata (lb1_rd)
  );

  canny_line_buf #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb2 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (rd_addr),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  // Incoming column: two rows up, one row up, current pixel
  always_comb begin
    new_col[0] = lb2_rd;
    new_col[1] = lb1_rd;
    new_col[2] = accept ? in_mag : '0;
  end

  assign top_out   = (cy == '0);
  assign bot_out   = (cy == ROW_LAST);
  assign left_out  = (cx == '0);
  assign right_out = (cx == COL_LAST);

  // Shifted window for this cycle, then border handling for the emitted centre
  always_comb begin
    logic row_oob;
    logic col_oob;
    row_oob = 1'b0;
    col_oob = 1'b0;
    for (int r = 0; r < 3; r++) begin
      w_n[r][0] = w_q[r][0];
      w_n[r][1] = w_q[r][1];
      w_n[r][2] = new_col[r];
    end
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        row_oob = ((r == 0) && top_out) || ((r == 2) && bot_out);
        col_oob = ((k == 0) && left_out) || ((k == 2) && right_out);
`ifdef MAG_WINDOW_REPLICATE_EN
        win_a[r][k] = w_n[row_oob ? 1 : r][col_oob ? 1 : k];
`else
        win_a[r][k] = (row_oob || col_oob) ? '0 : w_n[r][k];
`endif
      end
    end
  end

  // Pack the masked window into the output record
  always_comb begin
    win_d     = '0;
    win_d.c   = win_a[1][1];
    win_d.n00 = win_a[0][0];
    win_d.n01 = win_a[0][1];
    win_d.n02 = win_a[0][2];
    win_d.n10 = win_a[1][0];
    win_d.n12 = win_a[1][2];
    win_d.n20 = win_a[2][0];
    win_d.n21 = win_a[2][1];
    win_d.n22 = win_a[2][2];
  end

  // Keep the two most recent columns; the third comes straight from the line buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        w_q[r][0] <= '0;
        w_q[r][1] <= '0;
      end
    end else if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        w_q[r][0] <= w_n[r][1];
        w_q[r][1] <= w_n[r][2];
      end
    end
  end

  // Output register: window data holds while no window is emitted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_err <= 1'b0;
      win_q     <= '0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit && left_out && top_out;
      out_eof   <= emit && right_out && bot_out;
      frame_err <= resync;
      if (emit) win_q <= win_d;
    end
  end

  assign c   = win_q.c;
  assign n00 = win_q.n00;
  assign n01 = win_q.n01;
  assign n02 = win_q.n02;
  assign n10 = win_q.n10;
  assign n12 = win_q.n12;
  assign n20 = win_q.n20;
  assign n21 = win_q.n21;
  assign n22 = win_q.n22;

endmodule

// File: tb/tb_mag_window_3x3.sv
// Scoreboard bench for mag_window_3x3 on a 4x3 image.
module tb_mag_window_3x3;

  localparam int W = 4;
  localparam int H = 3;

  typedef struct packed {
    logic [15:0] c, n00, n01, n02, n10, n12, n20, n21, n22;
    logic        sof;
    logic        eof;
  } wrec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [15:0] in_mag = '0;
  logic        in_ready, out_valid, out_sof, out_eof, frame_err;
  logic [15:0] c, n00, n01, n02, n10, n12, n20, n21, n22;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    ferr_cnt = 0;
  int    img [H][W];
  wrec_t exp_q[$];
  wrec_t act_q[$];
  int    vcyc_q[$];
  int    acc_q[$];
  bit    rdy_log[$];
  bit    log_en = 1'b0;

  mag_window_3x3 #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mag    (in_mag),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .c         (c),
    .n00       (n00),
    .n01       (n01),
    .n02       (n02),
    .n10       (n10),
    .n12       (n12),
    .n20       (n20),
    .n21       (n21),
    .n22       (n22),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture DUT outputs mid-cycle
  always @(negedge clk) begin
    if (out_valid) begin
      act_q.push_back({c, n00, n01, n02, n10, n12, n20, n21, n22, out_sof, out_eof});
      vcyc_q.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (log_en) rdy_log.push_back(in_ready);
  end

  function automatic logic [15:0] pix(input int x, input int y);
    int xx;
    int yy;
    xx = x;
    yy = y;
`ifdef MAG_WINDOW_REPLICATE_EN
    if (xx < 0) xx = 0;
    if (xx > W - 1) xx = W - 1;
    if (yy < 0) yy = 0;
    if (yy > H - 1) yy = H - 1;
`else
    if (x < 0 || x >= W || y < 0 || y >= H) return 16'h0;
`endif
    return 16'(img[yy][xx]);
  endfunction

  function automatic wrec_t model_win(input int x, input int y, input bit sof, input bit eof);
    wrec_t r;
    r.c   = pix(x, y);
    r.n00 = pix(x - 1, y - 1);
    r.n01 = pix(x, y - 1);
    r.n02 = pix(x + 1, y - 1);
    r.n10 = pix(x - 1, y);
    r.n12 = pix(x + 1, y);
    r.n20 = pix(x - 1, y + 1);
    r.n21 = pix(x, y + 1);
    r.n22 = pix(x + 1, y + 1);
    r.sof = sof;
    r.eof = eof;
    return r;
  endfunction

  task automatic push_frame_expect();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back(model_win(x, y, (x == 0 && y == 0), (x == W - 1 && y == H - 1)));
  endtask

  // Hold one pixel on the bus until accepted, bounded
  task automatic drive_px(input int v, input bit sof);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_mag = 16'(v);
    in_sof = sof;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=0 required 1");
    end
    in_sof = 1'b0;
  endtask

  task automatic drive_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        drive_px(img[y][x], (x == 0 && y == 0));
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < 200 && act_q.size() < n; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    exp_q.delete();
    act_q.delete();
    vcyc_q.delete();
    acc_q.delete();
    rdy_log.delete();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    checks++; if (c !== 16'h0) begin errors++; $display("FAIL reset_c got %h required 0", c); end
    checks++; if (n22 !== 16'h0) begin errors++; $display("FAIL reset_n22 got %h required 0", n22); end
    checks++; if ({out_sof, out_eof, frame_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b required 000", {out_sof, out_eof, frame_err});
    end
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_impulse();
    wrec_t got, want;
    int n;
    clear_all();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 0;
    img[1][1] = 200;
    push_frame_expect();
    drive_frame();
    wait_drain(12);
    checks++;
    if (act_q.size() != 12) begin errors++; $display("FAIL impulse_count got %0d required 12", act_q.size()); end
    n = 0;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      got = act_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL impulse_win%0d got %h required %h", n, got, want); end
      n++;
    end
  endtask

  task automatic test_padding();
    wrec_t got, want;
    int n;
    clear_all();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 100;
    push_frame_expect();
    drive_frame();
    wait_drain(12);
    checks++;
    if (act_q.size() != 12) begin errors++; $display("FAIL padding_count got %0d required 12", act_q.size()); end
    n = 0;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      got = act_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL padding_win%0d got %h required %h", n, got, want); end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    wrec_t got, want;
    int n, run;
    int runs[$];
    clear_all();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = y * 16 + x + 1;
    push_frame_expect();
    log_en = 1'b1;
    drive_frame();
    wait_drain(12);
    log_en = 1'b0;
    run = 0;
    foreach (rdy_log[i]) begin
      if (!rdy_log[i]) run++;
      else if (run > 0) begin runs.push_back(run); run = 0; end
    end
    if (run > 0) runs.push_back(run);
    checks++;
    if (runs.size() != 3) begin errors++; $display("FAIL b2b_stall_runs got %0d required 3", runs.size()); end
    else begin
      checks++; if (runs[0] != 1) begin errors++; $display("FAIL b2b_stall_row0 got %0d required 1", runs[0]); end
      checks++; if (runs[1] != 1) begin errors++; $display("FAIL b2b_stall_row1 got %0d required 1", runs[1]); end
      checks++; if (runs[2] != 5) begin errors++; $display("FAIL b2b_stall_row2 got %0d required 5", runs[2]); end
    end
    checks++;
    if (acc_q.size() != 12 || vcyc_q.size() != 12) begin
      errors++; $display("FAIL b2b_counts got acc=%0d win=%0d required 12/12", acc_q.size(), vcyc_q.size());
    end else begin
      checks++; if (vcyc_q[0] != acc_q[5] + 1) begin
        errors++; $display("FAIL b2b_first_lat got %0d required %0d", vcyc_q[0], acc_q[5] + 1); end
      checks++; if (vcyc_q[3] != acc_q[7] + 2) begin
        errors++; $display("FAIL b2b_eol_lat got %0d required %0d", vcyc_q[3], acc_q[7] + 2); end
      checks++; if (vcyc_q[11] != acc_q[11] + 6) begin
        errors++; $display("FAIL b2b_flush_lat got %0d required %0d", vcyc_q[11], acc_q[11] + 6); end
    end
    n = 0;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      got = act_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL b2b_win%0d got %h required %h", n, got, want); end
      n++;
    end
  endtask

  task automatic test_resync();
    wrec_t got, want;
    int n, eofs;
    clear_all();
    ferr_cnt = 0;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 500 + y * W + x;
    exp_q.push_back(model_win(0, 0, 1'b1, 1'b0));
    for (int x = 0; x < W; x++) drive_px(img[0][x], (x == 0));
    drive_px(img[1][0], 1'b0);
    drive_px(img[1][1], 1'b0);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 900 + 7 * y + 3 * x;
    push_frame_expect();
    drive_frame();
    wait_drain(13);
    checks++;
    if (ferr_cnt != 1) begin errors++; $display("FAIL resync_ferr_cycles got %0d required 1", ferr_cnt); end
    checks++;
    if (act_q.size() != 13) begin errors++; $display("FAIL resync_count got %0d required 13", act_q.size()); end
    n = 0;
    eofs = 0;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      got = act_q.pop_front();
      want = exp_q.pop_front();
      eofs += int'(got.eof);
      checks++;
      if (got !== want) begin errors++; $display("FAIL resync_win%0d got %h required %h", n, got, want); end
      n++;
    end
    checks++;
    if (eofs != 1) begin errors++; $display("FAIL resync_eof_count got %0d required 1", eofs); end
  endtask

  task automatic test_reset_flush();
    wrec_t got, want;
    int n;
    clear_all();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 300 + x + 10 * y;
    drive_frame();
    // now in EOL after the last row; advance to the second flush cycle
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    act_q.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstflush_out_valid got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstflush_in_ready got %b required 1", in_ready); end
    checks++; if ({c, n00, n12, n21} !== 64'h0) begin
      errors++; $display("FAIL rstflush_data got %h required 0", {c, n00, n12, n21});
    end
    #10 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL rstflush_idle_windows got %0d required 0", act_q.size()); end
    act_q.delete();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 40 + 5 * x + 11 * y;
    push_frame_expect();
    drive_frame();
    wait_drain(12);
    checks++;
    if (act_q.size() != 12) begin errors++; $display("FAIL rstflush_count got %0d required 12", act_q.size()); end
    n = 0;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      got = act_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL rstflush_win%0d got %h required %h", n, got, want); end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_padding();
    test_back_to_back();
    test_resync();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
